fac_share_sched: RTL and testbench

- Scheduler that shares one LUT factorial unit (32-bit operand in, 64-bit factorial out, start/output_ready handshake) between NUM_REQ requesters.
- Sits between client blocks and the factorial datapath, one level above it.
- Grants requesters round-robin and sequences start and operand to the unit.
- Range-checks operands, enforces a completion timeout, and routes result and status back to the granted requester.

---
 rtl/fac_pkg.sv | 20 ++
 rtl/fac_rr_arbiter.sv | 37 +++
 rtl/fac_share_sched.sv | 163 ++++++++++++++++
 tb/tb_fac_share_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fac_pkg.sv
// Shared types and constants for the shared factorial scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fac_pkg;

   localparam int FAC_W = 64;
   localparam int NUM_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_RANGE   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/fac_rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is taken.
module fac_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W:0] cand;

   // Scan offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      sel  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
            cand = cand - (IDX_W + 1)'(NUM_REQ);
         end
         if (req[cand[IDX_W-1:0]]) begin
            sel                   = '0;
            sel[cand[IDX_W-1:0]]  = 1'b1;
            idx                   = cand[IDX_W-1:0];
            any                   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fac_share_sched.sv
// Shares one factorial unit among NUM_REQ requesters, round-robin, with range check and timeout.
// Latency: grant->fac_start 1 cycle, fac_ready->resp_valid 1 cycle, range error resp 1 cycle after grant.
// Backpressure: one job in flight; req is only sampled in IDLE, held requests simply wait their turn.
module fac_share_sched
   import fac_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MAX_N   = 20,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk_32b,
   input  logic                       reset_32b,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_W*NUM_REQ-1:0]   req_number,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [FAC_W-1:0]           resp_data,
   output logic [1:0]                 resp_err,
   output logic                       busy,
   output logic                       fac_start,
   output logic [NUM_W-1:0]           fac_number,
   input  logic [FAC_W-1:0]           fac_result,
   input  logic                       fac_ready
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_W-1:0]   operand_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [FAC_W-1:0]   resp_data_q;
   logic [1:0]         resp_err_q;

   logic [NUM_REQ-1:0] arb_sel;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic [NUM_W-1:0]   arb_num;

   logic               latch_job;
   logic               range_bad;
   logic               done_ok;
   logic               done_to;
   logic               timeout_hit;

   fac_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .sel (arb_sel),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign arb_num     = req_number[int'(arb_idx) * NUM_W +: NUM_W];
   // The counter starts at 0 in the first WAIT cycle; its incremented value reaching
   // TIMEOUT-1 marks the last cycle we wait, so the abort response lands TIMEOUT cycles after start.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 2));

   assign busy       = (state != IDLE);
   assign fac_number = operand_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

   // Next-state and per-cycle strobes; grant is held off while reset is asserted.
   always_comb begin
      state_nxt  = state;
      grant      = '0;
      fac_start  = 1'b0;
      resp_valid = '0;
      latch_job  = 1'b0;
      range_bad  = 1'b0;
      done_ok    = 1'b0;
      done_to    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any && !reset_32b) begin
               grant     = arb_sel;
               latch_job = 1'b1;
               if (arb_num > NUM_W'(MAX_N)) begin
                  range_bad = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            fac_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (fac_ready) begin
               done_ok   = 1'b1;
               state_nxt = RESP;
            end else if (timeout_hit) begin
               done_to   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            resp_valid = NUM_REQ'(1) << idx_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_32b or posedge reset_32b) begin
      if (reset_32b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the winner's index and operand at grant and advance the round-robin pointer past it.
   always_ff @(posedge clk_32b or posedge reset_32b) begin
      if (reset_32b) begin
         rr_ptr    <= '0;
         idx_q     <= '0;
         operand_q <= '0;
      end else if (latch_job) begin
         idx_q     <= arb_idx;
         operand_q <= arb_num;
         rr_ptr    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
   end

   // Timeout counter: cleared while issuing, counts every WAIT cycle.
   always_ff @(posedge clk_32b or posedge reset_32b) begin
      if (reset_32b) begin
         cnt_q <= '0;
      end else if (state == ISSUE) begin
         cnt_q <= '0;
      end else if (state == WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Response registers load only when a job finishes, so stray fac_ready pulses are ignored.
   always_ff @(posedge clk_32b or posedge reset_32b) begin
      if (reset_32b) begin
         resp_data_q <= '0;
         resp_err_q  <= ERR_OK;
      end else if (range_bad) begin
         resp_data_q <= '0;
         resp_err_q  <= ERR_RANGE;
      end else if (done_ok) begin
         resp_data_q <= fac_result;
         resp_err_q  <= ERR_OK;
      end else if (done_to) begin
         resp_data_q <= '0;
         resp_err_q  <= ERR_TIMEOUT;
      end
   end

endmodule

// File: tb/tb_fac_share_sched.sv
// Scoreboard bench for fac_share_sched with a behavioural factorial unit.
// Expected grants, operands and responses are queued at stimulus time.
// A negedge monitor pops and compares whenever the DUT presents them.
module tb_fac_share_sched;
   import fac_pkg::*;

   localparam int NREQ = 4;

   logic              clk_32b = 1'b0;
   logic              reset_32b;
   logic [NREQ-1:0]   req;
   logic [32*NREQ-1:0] req_number;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   resp_valid;
   logic [63:0]       resp_data;
   logic [1:0]        resp_err;
   logic              busy;
   logic              fac_start;
   logic [31:0]       fac_number;
   logic [63:0]       fac_result;
   logic              fac_ready;

   logic              mdl_ready;
   logic [63:0]       mdl_result;
   logic              stray_ready;

   assign fac_ready  = mdl_ready | stray_ready;
   assign fac_result = stray_ready ? 64'hDEAD_BEEF_0BAD_F00D : mdl_result;

   always #5 clk_32b = ~clk_32b;

   fac_share_sched #(
      .NUM_REQ (NREQ),
      .MAX_N   (20),
      .TIMEOUT (64)
   ) dut (
      .clk_32b    (clk_32b),
      .reset_32b  (reset_32b),
      .req        (req),
      .req_number (req_number),
      .grant      (grant),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .fac_start  (fac_start),
      .fac_number (fac_number),
      .fac_result (fac_result),
      .fac_ready  (fac_ready)
   );

   typedef struct {
      int          idx;
      logic [63:0] data;
      logic [1:0]  err;
      bit          chk_data;
   } resp_t;

   resp_t       exp_resp_q[$];
   int          exp_grant_q[$];
   logic [31:0] exp_num_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int grant_cnt = 0;
   int start_cnt = 0;
   int last_grant_cyc = 0;
   int last_start_cyc = 0;
   int last_resp_cyc = 0;

   int          mdl_delay = 5;
   int          mdl_cnt = 0;
   logic [31:0] mdl_num = '0;

   int          mon_idx;
   logic [31:0] mon_num;
   resp_t       mon_r;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic logic [63:0] fact(input logic [31:0] n);
      logic [63:0] f;
      f = 64'd1;
      for (int i = 2; i <= int'(n); i++) f = f * 64'(i);
      return f;
   endfunction

   initial forever begin
      @(posedge clk_32b);
      cyc++;
   end

   // Behavioural factorial unit: fac_ready pulses mdl_delay cycles after fac_start (0 = never).
   initial begin
      mdl_ready  = 1'b0;
      mdl_result = '0;
      forever begin
         @(negedge clk_32b);
         if (!reset_32b && fac_start) begin
            mdl_num = fac_number;
            mdl_cnt = mdl_delay;
         end
         @(posedge clk_32b);
         #1;
         mdl_ready = 1'b0;
         if (reset_32b) begin
            mdl_cnt = 0;
         end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
               mdl_ready  = 1'b1;
               mdl_result = fact(mdl_num);
            end
         end
      end
   end

   // Monitor: compares every grant, fac_start and response against the queued expectations.
   initial forever begin
      @(negedge clk_32b);
      if (grant != '0) begin
         grant_cnt++;
         last_grant_cyc = cyc;
         if (exp_grant_q.size() == 0) begin
            chk("grant_unexpected", 64'(grant), 64'd0);
         end else begin
            mon_idx = exp_grant_q.pop_front();
            chk("grant_onehot", 64'(grant), 64'd1 << mon_idx);
         end
      end
      if (fac_start) begin
         start_cnt++;
         last_start_cyc = cyc;
         if (exp_num_q.size() == 0) begin
            chk("start_unexpected", 64'(fac_start), 64'd0);
         end else begin
            mon_num = exp_num_q.pop_front();
            chk("fac_number", 64'(fac_number), 64'(mon_num));
         end
      end
      if (resp_valid != '0) begin
         last_resp_cyc = cyc;
         if (exp_resp_q.size() == 0) begin
            chk("resp_unexpected", 64'(resp_valid), 64'd0);
         end else begin
            mon_r = exp_resp_q.pop_front();
            chk("resp_valid_idx", 64'(resp_valid), 64'd1 << mon_r.idx);
            if (mon_r.chk_data) chk("resp_data", resp_data, mon_r.data);
            chk("resp_err", 64'(resp_err), 64'(mon_r.err));
         end
      end
   end

   task automatic wait_grant(input int target, input int bound, input string name);
      int k;
      k = 0;
      while (grant_cnt < target && k < bound) begin
         @(posedge clk_32b);
         #2;
         k++;
      end
      if (grant_cnt < target) fail_bound(name);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 300) begin
         @(posedge clk_32b);
         #2;
         k++;
      end
      if (busy) fail_bound(name);
   endtask

   task automatic expect_job(input int i, input logic [31:0] n, input logic [63:0] d,
                             input logic [1:0] err, input bit cd, input bit has_resp);
      resp_t r;
      exp_grant_q.push_back(i);
      if (err != ERR_RANGE) exp_num_q.push_back(n);
      if (has_resp) begin
         r.idx = i;
         r.data = d;
         r.err = err;
         r.chk_data = cd;
         exp_resp_q.push_back(r);
      end
   endtask

   task automatic do_job(input int i, input logic [31:0] n, input int dly,
                         input logic [63:0] d, input logic [1:0] err, input string name);
      int tgt;
      expect_job(i, n, d, err, (err != ERR_RANGE), 1'b1);
      mdl_delay = dly;
      req_number[i*32 +: 32] = n;
      req[i] = 1'b1;
      tgt = grant_cnt + 1;
      wait_grant(tgt, 40, name);
      req[i] = 1'b0;
      req_number[i*32 +: 32] = 32'hFFFF_FFFF;
      wait_idle(name);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},      64'(grant), 64'd0);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_resp_data"},  resp_data, 64'd0);
      chk({tag, "_resp_err"},   64'(resp_err), 64'd0);
      chk({tag, "_busy"},       64'(busy), 64'd0);
      chk({tag, "_fac_start"},  64'(fac_start), 64'd0);
      chk({tag, "_fac_number"}, 64'(fac_number), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int tgt;
      reset_32b   = 1'b1;
      req         = '0;
      req_number  = '0;
      stray_ready = 1'b0;
      repeat (3) @(posedge clk_32b);
      #2;
      chk_all_zero("reset");
      @(negedge clk_32b);
      reset_32b = 1'b0;
      @(posedge clk_32b);
      #1;

      // Single request and latency.
      do_job(0, 32'd12, 5, 64'd479001600, ERR_OK, "op12");
      chk("lat_grant_to_start", 64'(last_start_cyc - last_grant_cyc), 64'd1);
      chk("lat_start_to_resp", 64'(last_resp_cyc - last_start_cyc), 64'd6);

      // Boundaries.
      do_job(0, 32'd20, 3, 64'd2432902008176640000, ERR_OK, "op20");
      do_job(0, 32'd0, 2, 64'd1, ERR_OK, "op0");
      do_job(2, 32'd1, 1, 64'd1, ERR_OK, "op1_min_job");
      chk("min_job_start_to_resp", 64'(last_resp_cyc - last_start_cyc), 64'd2);
      s0 = start_cnt;
      do_job(3, 32'd21, 5, 64'd0, ERR_RANGE, "op21");
      chk("range_latency", 64'(last_resp_cyc - last_grant_cyc), 64'd1);
      chk("range_no_start", 64'(start_cnt), 64'(s0));

      // Contention: pointer is 0 after serving index 3.
      expect_job(0, 32'd3, 64'd6,   ERR_OK, 1'b1, 1'b1);
      expect_job(1, 32'd4, 64'd24,  ERR_OK, 1'b1, 1'b1);
      expect_job(3, 32'd6, 64'd720, ERR_OK, 1'b1, 1'b1);
      expect_job(0, 32'd3, 64'd6,   ERR_OK, 1'b1, 1'b1);
      mdl_delay = 2;
      req_number[0*32 +: 32] = 32'd3;
      req_number[1*32 +: 32] = 32'd4;
      req_number[3*32 +: 32] = 32'd6;
      tgt = grant_cnt + 4;
      req = 4'b1011;
      wait_grant(tgt, 100, "contention");
      req = '0;
      wait_idle("contention");

      // Timeout with no fac_ready.
      do_job(1, 32'd7, 0, 64'd0, ERR_TIMEOUT, "timeout");
      chk("timeout_latency", 64'(last_resp_cyc - last_start_cyc), 64'd64);
      @(posedge clk_32b);
      #1;
      @(posedge clk_32b);
      #1;
      stray_ready = 1'b1;
      @(posedge clk_32b);
      #1;
      stray_ready = 1'b0;
      @(posedge clk_32b);
      #2;
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_resp_data", resp_data, 64'd0);
      chk("stray_resp_err", 64'(resp_err), 64'(ERR_TIMEOUT));

      // Reset mid-WAIT: pointer is 2, so index 2 wins and pointer moves to 3.
      expect_job(2, 32'd9, 64'd0, ERR_OK, 1'b0, 1'b0);
      mdl_delay = 30;
      req_number[2*32 +: 32] = 32'd9;
      tgt = grant_cnt + 1;
      req[2] = 1'b1;
      wait_grant(tgt, 40, "abort_grant");
      req[2] = 1'b0;
      repeat (4) @(posedge clk_32b);
      #3;
      reset_32b = 1'b1;
      #1;
      chk_all_zero("abort");
      repeat (2) @(posedge clk_32b);
      @(negedge clk_32b);
      reset_32b = 1'b0;
      @(posedge clk_32b);
      #1;

      // After reset the pointer is 0, so index 2 beats index 3.
      expect_job(2, 32'd5, 64'd120, ERR_OK, 1'b1, 1'b1);
      expect_job(3, 32'd6, 64'd720, ERR_OK, 1'b1, 1'b1);
      mdl_delay = 4;
      req_number[2*32 +: 32] = 32'd5;
      req_number[3*32 +: 32] = 32'd6;
      tgt = grant_cnt + 2;
      req = 4'b1100;
      wait_grant(tgt, 60, "post_reset");
      req = '0;
      wait_idle("post_reset");
      repeat (3) @(posedge clk_32b);
      #2;

      chk("sb_resp_left",  64'(exp_resp_q.size()), 64'd0);
      chk("sb_grant_left", 64'(exp_grant_q.size()), 64'd0);
      chk("sb_num_left",   64'(exp_num_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
